// File: rtl/vram_frame_writer.sv
// vram_frame_writer: captures a 640x480 grayscale stream, downscales it 2:1 in
// both directions (horizontal pair average, odd rows dropped) and writes the
// 320x240 result row-major into the frame-buffer VRAM write port.
module vram_frame_writer #(
    parameter int unsigned IN_W  = 640,
    parameter int unsigned IN_H  = 480,
    parameter int unsigned OUT_W = 320
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        continuous,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic        in_eol,
    input  logic [7:0]  in_data,
    input  logic        err_clr,
    output logic        vram_wr_en,
    output logic [16:0] vram_wr_addr,
    output logic [7:0]  vram_wr_data,
    output logic        busy,
    output logic        frame_done,
    output logic        line_err,
    output logic        frame_err
);

    localparam int unsigned XW = 10;
    localparam int unsigned YW = 9;
    localparam int unsigned AW = 17;
    localparam int unsigned DW = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_SOF,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [DW-1:0]   first_q, first_d;
    logic            skip_q, skip_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            line_err_q, line_err_d;
    logic            frame_err_q, frame_err_d;

    // Combinational helpers for the pixel being accepted this cycle
    logic            proc;
    logic [XW-1:0]   px_x;
    logic [YW-1:0]   px_y;
    logic            line_end;
    logic            new_line_err;
    logic            new_frame_err;
    logic [YW-2:0]   row;
    logic [AW-1:0]   row_base;
    logic [DW:0]     pair_sum;

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            first_q     <= '0;
            skip_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            first_q     <= first_d;
            skip_q      <= skip_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state, pixel processing and registered-output next values
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        first_d       = first_q;
        skip_d        = skip_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        proc          = 1'b0;
        px_x          = x_q;
        px_y          = y_q;
        line_end      = 1'b0;
        new_line_err  = 1'b0;
        new_frame_err = 1'b0;
        row           = '0;
        row_base      = '0;
        pair_sum      = '0;

        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_WAIT_SOF;
            end
            S_WAIT_SOF: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (in_valid) begin
                    if (in_sof) begin
                        proc    = 1'b1;
                        px_x    = '0;
                        px_y    = '0;
                        skip_d  = 1'b0;
                        state_d = S_CAPTURE;
                    end else if (in_eol) begin
                        new_frame_err = 1'b1;
                    end
                end
            end
            S_CAPTURE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (in_valid) begin
                    if (in_sof) begin
                        // A start-of-frame anywhere but (0,0) restarts the frame
                        proc   = 1'b1;
                        px_x   = '0;
                        px_y   = '0;
                        skip_d = 1'b0;
                        if ((x_q != '0) || (y_q != '0)) new_frame_err = 1'b1;
                    end else if (skip_q) begin
                        // Overlong line: drop pixels until its in_eol
                        if (in_eol) skip_d = 1'b0;
                    end else begin
                        proc = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = (continuous && enable) ? S_WAIT_SOF : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (proc) begin
            line_end = in_eol || (px_x == XW'(IN_W - 1));
            row      = px_y[YW-1:1];
            if (OUT_W == 320) begin
                row_base = (AW'(row) << 8) + (AW'(row) << 6);
            end else begin
                row_base = AW'(row * OUT_W);
            end
            pair_sum = {1'b0, first_q} + {1'b0, in_data} + (DW+1)'(1);

            if (!px_y[0]) begin
                if (!px_x[0]) begin
                    first_d = in_data;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = row_base + AW'(px_x[XW-1:1]);
                    wr_data_d = pair_sum[DW:1];
                end
            end

            if (line_end) begin
                x_d = '0;
                y_d = px_y + YW'(1);
                if (in_eol && (px_x != XW'(IN_W - 1))) new_line_err = 1'b1;
                if (!in_eol) begin
                    new_line_err = 1'b1;
                    skip_d       = 1'b1;
                end
                if (px_y == YW'(IN_H - 1)) begin
                    state_d = S_DONE;
                    skip_d  = 1'b0;
                end
            end else begin
                x_d = px_x + XW'(1);
                y_d = px_y;
            end
        end

        // A newly detected error wins over a same-cycle clear
        line_err_d  = (line_err_q && !err_clr) || new_line_err;
        frame_err_d = (frame_err_q && !err_clr) || new_frame_err;
        busy_d      = (state_d == S_WAIT_SOF) || (state_d == S_CAPTURE);
        done_d      = (state_d == S_DONE);
    end

    assign vram_wr_en   = wr_en_q;
    assign vram_wr_addr = wr_addr_q;
    assign vram_wr_data = wr_data_q;
    assign busy         = busy_q;
    assign frame_done   = done_q;
    assign line_err     = line_err_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_vram_frame_writer.sv
// Testbench for vram_frame_writer: scenario tasks push expected VRAM writes to
// a queue; a negedge monitor pops and compares every write the DUT issues.
module tb_vram_frame_writer;

    localparam int unsigned IN_W  = 640;
    localparam int unsigned IN_H  = 480;
    localparam int unsigned OUT_W = 320;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        enable = 1'b0;
    logic        continuous = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic        in_eol = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        err_clr = 1'b0;
    logic        vram_wr_en;
    logic [16:0] vram_wr_addr;
    logic [7:0]  vram_wr_data;
    logic        busy;
    logic        frame_done;
    logic        line_err;
    logic        frame_err;

    typedef struct packed {
        logic [16:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    int          checks = 0;
    int          errors = 0;
    int          wr_count = 0;
    int          done_count = 0;
    logic [16:0] last_addr = '0;

    vram_frame_writer #(.IN_W(IN_W), .IN_H(IN_H), .OUT_W(OUT_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .continuous  (continuous),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .in_eol      (in_eol),
        .in_data     (in_data),
        .err_clr     (err_clr),
        .vram_wr_en  (vram_wr_en),
        .vram_wr_addr(vram_wr_addr),
        .vram_wr_data(vram_wr_data),
        .busy        (busy),
        .frame_done  (frame_done),
        .line_err    (line_err),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    // Monitor: count frame_done pulses and score every VRAM write
    always @(negedge clk) begin
        if (frame_done) done_count++;
        if (vram_wr_en) begin
            wr_count++;
            last_addr = vram_wr_addr;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%02h required none", vram_wr_addr, vram_wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (vram_wr_addr !== mon_e.addr || vram_wr_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL write addr=%0d data=%02h required addr=%0d data=%02h",
                             vram_wr_addr, vram_wr_data, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] pat(input int x, input int seed);
        return 8'((x + seed) % 256);
    endfunction

    function automatic logic [7:0] avg(input logic [7:0] a, input logic [7:0] b);
        return 8'((int'(a) + int'(b) + 1) / 2);
    endfunction

    task automatic push_wr(input int addr, input logic [7:0] data);
        wr_t e;
        e.addr = 17'(addr);
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_pix(input logic [7:0] d, input logic sof, input logic eol);
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        in_eol   = eol;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eol   = 1'b0;
    endtask

    // Pixels x0..len-1 of line y; pairs completing at odd x <= IN_W-1 on even rows write
    task automatic send_line(input int y, input int x0, input int len, input int seed,
                             input bit sof, input bit eol);
        for (int x = x0; x < len; x++) begin
            if ((y % 2 == 0) && (x % 2 == 1) && (x <= int'(IN_W) - 1) && (x - 1 >= x0))
                push_wr((y / 2) * int'(OUT_W) + x / 2, avg(pat(x - 1, seed), pat(x, seed)));
            send_pix(pat(x, seed), sof && (x == 0), eol && (x == len - 1));
        end
    endtask

    // One-pixel lines (eol at x=0): advance rows without any writes
    task automatic short_rows(input int y0, input int y1);
        for (int y = y0; y <= y1; y++) send_pix(8'h55, 1'b0, 1'b1);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (vram_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b required=0", vram_wr_en); end
        checks++; if (vram_wr_addr !== 17'd0) begin errors++; $display("FAIL reset_wr_addr got=%0d required=0", vram_wr_addr); end
        checks++; if (vram_wr_data !== 8'd0) begin errors++; $display("FAIL reset_wr_data got=%0d required=0", vram_wr_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b required=0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%b required=0", frame_done); end
        checks++; if ({line_err, frame_err} !== 2'b00) begin errors++; $display("FAIL reset_errs got=%b required=00", {line_err, frame_err}); end
        #2 reset_n = 1'b1;
        idle(2);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy got=%b required=0", busy); end
    endtask

    task automatic test_frame();
        int d0, w0;
        continuous = 1'b0;
        enable = 1'b1;
        idle(2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_wait_sof_busy got=%b required=1", busy); end
        d0 = done_count;
        w0 = wr_count;
        for (int y = 0; y < 4; y++) send_line(y, 0, IN_W, 0, y == 0, 1'b1);
        short_rows(4, IN_H - 3);
        send_line(IN_H - 2, 0, IN_W, 0, 1'b0, 1'b1);
        send_pix(8'h00, 1'b0, 1'b1);
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL frame_done_pulse got=%b required=1", frame_done); end
        enable = 1'b0;
        idle(3);
        checks++; if (done_count - d0 != 1) begin errors++; $display("FAIL frame_done_count got=%0d required=1", done_count - d0); end
        checks++; if (wr_count - w0 != 960) begin errors++; $display("FAIL frame_write_count got=%0d required=960", wr_count - w0); end
        checks++; if (last_addr !== 17'd76799) begin errors++; $display("FAIL frame_last_addr got=%0d required=76799", last_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_end_busy got=%b required=0", busy); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL frame_missing_writes got=%0d required=0", exp_q.size()); end
        checks++; if (line_err !== 1'b1) begin errors++; $display("FAIL frame_short_line_err got=%b required=1", line_err); end
        pulse_clr();
        checks++; if (line_err !== 1'b0) begin errors++; $display("FAIL frame_err_clr got=%b required=0", line_err); end
    endtask

    task automatic test_round_skip();
        int d0, w0;
        enable = 1'b1;
        idle(2);
        d0 = done_count;
        w0 = wr_count;
        push_wr(0, 8'hFF);
        send_pix(8'hFF, 1'b1, 1'b0);
        send_pix(8'hFE, 1'b0, 1'b0);
        push_wr(1, 8'h01);
        send_pix(8'h00, 1'b0, 1'b0);
        send_pix(8'h01, 1'b0, 1'b0);
        send_line(0, 4, IN_W, 0, 1'b0, 1'b1);
        send_line(1, 0, IN_W, 7, 1'b0, 1'b1);
        send_line(2, 0, IN_W, 3, 1'b0, 1'b1);
        idle(3);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL round_missing_writes got=%0d required=0", exp_q.size()); end
        checks++; if (wr_count - w0 != 640) begin errors++; $display("FAIL round_row_skip_count got=%0d required=640", wr_count - w0); end
        enable = 1'b0;
        idle(2);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b required=0", busy); end
        checks++; if (done_count != d0) begin errors++; $display("FAIL abort_no_done got=%0d required=%0d", done_count, d0); end
    endtask

    task automatic test_short_line();
        pulse_clr();
        checks++; if (line_err !== 1'b0) begin errors++; $display("FAIL short_pre_clr got=%b required=0", line_err); end
        enable = 1'b1;
        idle(2);
        for (int y = 0; y < 4; y++) send_line(y, 0, IN_W, 1, y == 0, 1'b1);
        send_line(4, 0, 100, 5, 1'b0, 1'b0);
        err_clr = 1'b1;
        send_pix(pat(100, 5), 1'b0, 1'b1);
        err_clr = 1'b0;
        checks++; if (line_err !== 1'b1) begin errors++; $display("FAIL short_err_beats_clr got=%b required=1", line_err); end
        send_line(5, 0, IN_W, 2, 1'b0, 1'b1);
        send_line(6, 0, IN_W, 9, 1'b0, 1'b1);
        idle(3);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL short_missing_writes got=%0d required=0", exp_q.size()); end
        pulse_clr();
        checks++; if (line_err !== 1'b0) begin errors++; $display("FAIL short_clr got=%b required=0", line_err); end
        enable = 1'b0;
        idle(2);
    endtask

    task automatic test_long_line();
        int w0;
        enable = 1'b1;
        idle(2);
        w0 = wr_count;
        send_line(0, 0, 650, 11, 1'b1, 1'b1);
        send_line(1, 0, IN_W, 4, 1'b0, 1'b1);
        send_line(2, 0, IN_W, 13, 1'b0, 1'b1);
        idle(3);
        checks++; if (line_err !== 1'b1) begin errors++; $display("FAIL long_line_err got=%b required=1", line_err); end
        checks++; if (wr_count - w0 != 640) begin errors++; $display("FAIL long_write_count got=%0d required=640", wr_count - w0); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL long_missing_writes got=%0d required=0", exp_q.size()); end
        enable = 1'b0;
        idle(2);
        pulse_clr();
    endtask

    task automatic test_frame_err();
        int d0;
        enable = 1'b1;
        idle(2);
        send_pix(8'h10, 1'b0, 1'b1);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL eol_in_wait_sof got=%b required=1", frame_err); end
        pulse_clr();
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL frame_err_clr got=%b required=0", frame_err); end
        d0 = done_count;
        send_line(0, 0, IN_W, 0, 1'b1, 1'b1);
        short_rows(1, 199);
        send_line(200, 0, 10, 0, 1'b0, 1'b0);
        push_wr(0, avg(8'h20, 8'h21));
        send_pix(8'h20, 1'b1, 1'b0);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL mid_frame_sof got=%b required=1", frame_err); end
        send_pix(8'h21, 1'b0, 1'b0);
        send_line(0, 2, IN_W, 0, 1'b0, 1'b1);
        short_rows(1, IN_H - 2);
        checks++; if (done_count != d0) begin errors++; $display("FAIL aborted_frame_done got=%0d required=%0d", done_count, d0); end
        send_pix(8'h00, 1'b0, 1'b1);
        enable = 1'b0;
        idle(3);
        checks++; if (done_count - d0 != 1) begin errors++; $display("FAIL restarted_frame_done got=%0d required=1", done_count - d0); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL restart_missing_writes got=%0d required=0", exp_q.size()); end
        pulse_clr();
    endtask

    task automatic test_continuous();
        int d0;
        continuous = 1'b1;
        enable = 1'b1;
        idle(2);
        d0 = done_count;
        send_line(0, 0, IN_W, 21, 1'b1, 1'b1);
        short_rows(1, IN_H - 1);
        idle(4);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cont_busy_between got=%b required=1", busy); end
        checks++; if (done_count - d0 != 1) begin errors++; $display("FAIL cont_first_done got=%0d required=1", done_count - d0); end
        send_line(0, 0, IN_W, 33, 1'b1, 1'b1);
        short_rows(1, IN_H - 1);
        enable = 1'b0;
        idle(3);
        checks++; if (done_count - d0 != 2) begin errors++; $display("FAIL cont_done_count got=%0d required=2", done_count - d0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_end_busy got=%b required=0", busy); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL cont_missing_writes got=%0d required=0", exp_q.size()); end
        continuous = 1'b0;
        pulse_clr();
    endtask

    task automatic test_async_reset();
        int w0;
        enable = 1'b1;
        idle(2);
        send_line(0, 0, 8, 40, 1'b1, 1'b0);
        checks++; if (vram_wr_en !== 1'b1) begin errors++; $display("FAIL pre_reset_wr_en got=%b required=1", vram_wr_en); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (vram_wr_en !== 1'b0) begin errors++; $display("FAIL async_wr_en got=%b required=0", vram_wr_en); end
        checks++; if (vram_wr_addr !== 17'd0) begin errors++; $display("FAIL async_wr_addr got=%0d required=0", vram_wr_addr); end
        checks++; if (vram_wr_data !== 8'd0) begin errors++; $display("FAIL async_wr_data got=%0d required=0", vram_wr_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy got=%b required=0", busy); end
        exp_q.delete();
        enable = 1'b0;
        #2 reset_n = 1'b1;
        idle(2);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle got=%b required=0", busy); end
        enable = 1'b1;
        idle(2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL post_reset_wait_sof got=%b required=1", busy); end
        w0 = wr_count;
        for (int x = 0; x < int'(IN_W); x++) send_pix(pat(x, 0), 1'b0, 1'b0);
        idle(3);
        checks++; if (wr_count != w0) begin errors++; $display("FAIL no_sof_writes got=%0d required=0", wr_count - w0); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL async_queue got=%0d required=0", exp_q.size()); end
        enable = 1'b0;
        idle(2);
    endtask

    initial begin
        test_reset();
        test_frame();
        test_round_skip();
        test_short_line();
        test_long_line();
        test_frame_err();
        test_continuous();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
